// File: rtl/exec_unit_mdu_if.sv
// Execute-stage bus: operand/op handshake from upstream plus result, status and HI/LO
// observation back from the ALU/MDU unit.
interface exec_unit_mdu_if #(
    parameter int WIDTH = 32
) ();
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output in_valid, op, a, b, shamt,
        input  in_ready, out_valid, result, overflow, busy, hi, lo
    );

    modport slave (
        input  in_valid, op, a, b, shamt,
        output in_ready, out_valid, result, overflow, busy, hi, lo
    );
endinterface

// File: rtl/exec_unit_mdu.sv
// Execute-stage unit: single-cycle ALU with registered result, plus a fixed-latency
// multiply/divide unit that owns HI/LO and stalls the handshake while it runs.
module exec_unit_mdu #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input logic             clk,
    input logic             reset_n,
    exec_unit_mdu_if.slave  bus
);
    localparam int SHW  = $clog2(WIDTH);
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [4:0] {
        OP_AND   = 5'd0,  OP_OR    = 5'd1,  OP_XOR   = 5'd2,  OP_NOR   = 5'd3,
        OP_ADD   = 5'd4,  OP_SUB   = 5'd5,  OP_SLL   = 5'd6,  OP_SRL   = 5'd7,
        OP_SRA   = 5'd8,  OP_SLLV  = 5'd9,  OP_SRLV  = 5'd10, OP_SRAV  = 5'd11,
        OP_SLT   = 5'd12, OP_SLTU  = 5'd13, OP_PASSB = 5'd14, OP_PASSA = 5'd15,
        OP_MULT  = 5'd16, OP_MULTU = 5'd17, OP_DIV   = 5'd18, OP_DIVU  = 5'd19,
        OP_MFHI  = 5'd20, OP_MFLO  = 5'd21, OP_MTHI  = 5'd22, OP_MTLO  = 5'd23
    } op_e;

    logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
    logic             overflow_q, overflow_d, valid_q, valid_d;
    logic             is_div_q, is_div_d, is_sgn_q, is_sgn_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             idle;

    assign idle = (cnt_q == '0);

    // ---------------- ALU ----------------
    logic [SHW-1:0]   sh_amt;
    logic [WIDTH:0]   add_x, sub_x;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    assign sh_amt = (bus.op == OP_SLL || bus.op == OP_SRL || bus.op == OP_SRA)
                    ? bus.shamt : bus.a[SHW-1:0];
    assign add_x  = {bus.a[WIDTH-1], bus.a} + {bus.b[WIDTH-1], bus.b};
    assign sub_x  = {bus.a[WIDTH-1], bus.a} - {bus.b[WIDTH-1], bus.b};

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.op)
            OP_AND:   alu_res = bus.a & bus.b;
            OP_OR:    alu_res = bus.a | bus.b;
            OP_XOR:   alu_res = bus.a ^ bus.b;
            OP_NOR:   alu_res = ~(bus.a | bus.b);
            OP_ADD:   begin alu_res = add_x[WIDTH-1:0]; alu_ovf = add_x[WIDTH] ^ add_x[WIDTH-1]; end
            OP_SUB:   begin alu_res = sub_x[WIDTH-1:0]; alu_ovf = sub_x[WIDTH] ^ sub_x[WIDTH-1]; end
            OP_SLL,  OP_SLLV: alu_res = bus.b << sh_amt;
            OP_SRL,  OP_SRLV: alu_res = bus.b >> sh_amt;
            OP_SRA,  OP_SRAV: alu_res = $signed(bus.b) >>> sh_amt;
            OP_SLT:   alu_res = WIDTH'($signed(bus.a) < $signed(bus.b));
            OP_SLTU:  alu_res = WIDTH'(bus.a < bus.b);
            OP_PASSB: alu_res = bus.b;
            OP_PASSA: alu_res = bus.a;
            OP_MFHI:  alu_res = hi_q;
            OP_MFLO:  alu_res = lo_q;
            default:  alu_res = '0;
        endcase
    end

    // ---------------- MDU arithmetic on latched operands ----------------
    // Evaluated from stable operand registers; the result is only committed on the
    // final busy cycle, so this logic has the whole busy window to settle.
    logic [2*WIDTH-1:0] mul_ax, mul_bx, product;
    logic               a_neg, b_neg, div_zero;
    logic [WIDTH-1:0]   a_mag, b_mag, divisor, q_mag, r_mag, quot, rem;

    assign mul_ax   = is_sgn_q ? {{WIDTH{opa_q[WIDTH-1]}}, opa_q} : {{WIDTH{1'b0}}, opa_q};
    assign mul_bx   = is_sgn_q ? {{WIDTH{opb_q[WIDTH-1]}}, opb_q} : {{WIDTH{1'b0}}, opb_q};
    assign product  = mul_ax * mul_bx;

    assign a_neg    = is_sgn_q & opa_q[WIDTH-1];
    assign b_neg    = is_sgn_q & opb_q[WIDTH-1];
    assign a_mag    = a_neg ? -opa_q : opa_q;
    assign b_mag    = b_neg ? -opb_q : opb_q;
    assign div_zero = (opb_q == '0);
    assign divisor  = div_zero ? WIDTH'(1) : b_mag;
    assign q_mag    = a_mag / divisor;
    assign r_mag    = a_mag % divisor;
    assign quot     = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem      = a_neg ? -r_mag : r_mag;

    // ---------------- next state ----------------
    always_comb begin
        result_d   = result_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;
        cnt_d      = cnt_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        is_div_d   = is_div_q;
        is_sgn_d   = is_sgn_q;
        if (!idle) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                if (!is_div_q) begin
                    {hi_d, lo_d} = product;
                end else if (!div_zero) begin
                    hi_d = rem;
                    lo_d = quot;
                end
            end
        end else if (bus.in_valid) begin
            case (bus.op)
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                    opa_d    = bus.a;
                    opb_d    = bus.b;
                    is_div_d = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
                    is_sgn_d = (bus.op == OP_MULT) || (bus.op == OP_DIV);
                    cnt_d    = is_div_d ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                end
                OP_MTHI: hi_d = bus.a;
                OP_MTLO: lo_d = bus.a;
                default: begin
                    result_d   = alu_res;
                    overflow_d = alu_ovf;
                    valid_d    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            result_q   <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            cnt_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            is_div_q   <= 1'b0;
            is_sgn_q   <= 1'b0;
        end else begin
            result_q   <= result_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            cnt_q      <= cnt_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            is_div_q   <= is_div_d;
            is_sgn_q   <= is_sgn_d;
        end
    end

    assign bus.in_ready  = idle;
    assign bus.busy      = !idle;
    assign bus.out_valid = valid_q;
    assign bus.result    = result_q;
    assign bus.overflow  = overflow_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule
